wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin arbiter that shares one Wishbone B4 peripheral-side bus between N Wishbone controllers, such as the SPI-driven Wishbone bridge and a second host bridge or an on-chip sequencer. It grants the bus for whole cycles: a grant is held from `cyc` rise to `cyc` fall. It routes `ack` and `dat` back only to the granted controller. An optional watchdog terminates transfers that a peripheral never acknowledges.

## Interface
Parameters:
- `N`, default 2: number of controllers, legal range 2..4.
- `TIMEOUT`, default 255: watchdog limit, in cycles of `stb` without `ack`. Legal range 2..65535. Used only with the watchdog compiled in.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ctrl_wb_c[N]`  in  `iWishbone_Ctrl`: requests from each controller.
- `ctrl_wb_p[N]`  out  `iWishbone_Peri`: responses to each controller.
- `wb_c`  out  `iWishbone_Ctrl`: shared bus toward peripherals/decoder.
- `wb_p`  in  `iWishbone_Peri`: shared bus response.
- `grant`  out  N: one-hot current owner; all zero when idle.
- `timeout`  out  1: single-cycle pulse on each watchdog termination.

## Operation
- Two states: IDLE and BUSY, plus a `last` register holding the index of the previous owner.
- IDLE:
  - `grant` = 0; `wb_c.cyc` = `wb_c.stb` = 0.
  - If any `ctrl_wb_c[i].cyc` = 1, pick the first requester scanning `last+1, last+2, …` (mod N).
  - Register its one-hot grant and go to BUSY.
- BUSY:
  - `wb_c` = `ctrl_wb_c[owner]`, combinational passthrough.
  - `ctrl_wb_p[owner]` = `wb_p`.
  - Every other controller sees `ack` = 0 and `dat` = 0.
- Release:
  - When `ctrl_wb_c[owner].cyc` = 0 in BUSY, `wb_c.cyc` drops in that same cycle through the passthrough.
  - Next state is IDLE, with `last` ← owner and `grant` ← 0.
- No preemption. A controller keeps the bus across any number of `stb`/`ack` beats while `cyc` is held.
- Non-owner requesters wait with `cyc` high; they see no `ack`.
- Fairness: with all N requesting continuously, ownership rotates 0,1,…,N-1,0,…

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, `grant` = 0, `last` = N-1 (controller 0 wins first), `timeout` = 0, watchdog counter = 0.
  - All `ctrl_wb_p[i].ack` = 0.
  - Reset mid-transfer drops `wb_c.cyc` immediately. The controller must restart its cycle.
- Grant latency: `cyc` sampled high in IDLE at edge k gives `grant` and `wb_c.cyc` high from edge k+1 onward.
- Back-to-back handover: release at edge k puts IDLE in cycle k+1, and the next owner is on the bus from edge k+2. There is always at least one idle bus cycle between owners.
- Simultaneous events:
  - Owner dropping `cyc` while another controller raises it: the new request is seen in IDLE on the following cycle.
  - Same controller re-asserting right after release: it loses to any other waiting requester.
- `ack` passthrough is combinational, with zero added latency in BUSY.

## Configuration
- `WB_ARBITER_TIMEOUT_EN` defined: a 16-bit counter runs in BUSY.
  - It clears on `ack`, on `stb` = 0, and on entry to BUSY.
  - It increments each cycle with `wb_c.stb` = 1 and `wb_p.ack` = 0.
  - At count = `TIMEOUT`-1 the arbiter, for one cycle:
    - drives `ctrl_wb_p[owner].ack` = 1 and `dat` = 0;
    - forces `wb_c.stb` = 0;
    - pulses `timeout` = 1;
    - clears the counter.
  - The grant is kept until the owner drops `cyc`.
- Not defined: no counter; `timeout` is tied to 0; a peripheral that never acks hangs the bus indefinitely.

## Test plan
- Single request: controller 0 raises `cyc`/`stb` at cycle 0 → `grant` = 01 and `wb_c` mirrors it at cycle 1. Peripheral `ack` with `dat` = 0xA5 → only `ctrl_wb_p[0]` sees `ack` and 0xA5.
- Contention after reset: controllers 0 and 1 request at the same edge → 0 is granted first. Controller 1 is granted 2 cycles after 0 drops `cyc`. Controller 1 saw no `ack` while waiting.
- Round-robin: N=3, all request continuously with 1-beat cycles → grant order 0,1,2,0,1,2.
- Burst hold: owner keeps `cyc` high across 4 `stb`/`ack` beats while controller 1 requests → no grant change until `cyc` falls.
- Watchdog (`WB_ARBITER_TIMEOUT_EN`, `TIMEOUT`=8): owner holds `stb` with no peripheral `ack`:
  - → synthetic `ack` with `dat` = 0 at the 8th stalled cycle;
  - `timeout` pulses once;
  - `wb_c.stb` is low for that cycle.
- Async reset mid-BUSY: assert `rst` between edges → `grant` = 0 and `wb_c.cyc` = 0 immediately. After release, controller 0 has priority.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of N Wishbone B4 links: request signals travel master->slave, ack/dat_r slave->master.
// N=1 instance is the shared peripheral bus; N>1 instance groups all controllers for the arbiter.
interface wb_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic [N-1:0]             cyc;
  logic [N-1:0]             stb;
  logic [N-1:0]             we;
  logic [N-1:0]             ack;
  logic [N-1:0][ADDR_W-1:0] adr;
  logic [N-1:0][DATA_W-1:0] dat_w;
  logic [N-1:0][DATA_W-1:0] dat_r;
  logic [N-1:0][SEL_W-1:0]  sel;

  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: N controllers share one bus, granted for whole cycles.
// Define WB_ARBITER_TIMEOUT_EN to build the no-ack watchdog (limit set by TIMEOUT).
module wb_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   ctrl_wb,
  wb_arbiter_if.master  wb,
  output logic [N-1:0]  grant,
  output logic          timeout
);
  localparam int IDX_W = (N > 2) ? 2 : 1;

  if (N < 2 || N > 4 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("wb_arbiter: N must be 2..4 and TIMEOUT 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q,  last_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              req_any;
  logic [IDX_W-1:0]  pick;
  logic              fire;

  // Rotating priority: first requester after the previous owner wins.
  always_comb begin : pick_next
    int unsigned      sum;
    logic [IDX_W-1:0] cand;
    sum     = 0;
    cand    = '0;
    req_any = 1'b0;
    pick    = '0;
    for (int k = 1; k <= N; k++) begin
      sum = 32'(last_q) + 32'(k);
      if (sum >= 32'(N)) sum = sum - 32'(N);
      cand = IDX_W'(sum);
      if (!req_any && ctrl_wb.cyc[cand]) begin
        req_any = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    grant_d       = grant_q;
    wb.cyc        = '0;
    wb.stb        = '0;
    wb.we         = '0;
    wb.adr        = '0;
    wb.dat_w      = '0;
    wb.sel        = '0;
    ctrl_wb.ack   = '0;
    ctrl_wb.dat_r = '0;
    timeout       = fire;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d       = BUSY;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        wb.cyc[0]               = ctrl_wb.cyc[owner_q];
        wb.stb[0]               = ctrl_wb.stb[owner_q] & ~fire;
        wb.we[0]                = ctrl_wb.we[owner_q];
        wb.adr[0]               = ctrl_wb.adr[owner_q];
        wb.dat_w[0]             = ctrl_wb.dat_w[owner_q];
        wb.sel[0]               = ctrl_wb.sel[owner_q];
        ctrl_wb.ack[owner_q]    = wb.ack[0] | fire;
        ctrl_wb.dat_r[owner_q]  = fire ? '0 : wb.dat_r[0];
        // Owner dropping cyc ends the tenure; the bus idles one cycle before the next owner.
        if (!ctrl_wb.cyc[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;

  // Counts stalled strobe cycles; any ack, idle strobe or termination restarts it.
  always_comb begin
    fire = (state_q == BUSY) && ctrl_wb.cyc[owner_q] && ctrl_wb.stb[owner_q] &&
           !wb.ack[0] && (wd_cnt_q == WD_LAST);
    wd_cnt_d = '0;
    if ((state_q == BUSY) && ctrl_wb.stb[owner_q] && !wb.ack[0] && !fire)
      wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end
`else
  assign fire = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter (N=3) against a cycle-level ownership model.
module tb_wb_arbiter;
  localparam int N = 3, TIMEOUT = 8, AW = 32, DW = 32;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) ctrl_bus ();
  wb_arbiter_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) peri_bus ();
  logic [N-1:0] grant;
  logic         timeout;

  wb_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ctrl_wb(ctrl_bus), .wb(peri_bus),
    .grant(grant), .timeout(timeout)
  );

  int n_tests = 0, n_fail = 0;
  // Reference model: who owns the bus, who owned it last, stalled strobe cycles.
  int m_owner = -1, m_last = N - 1, m_cnt = 0;
  logic [N-1:0]  obs_grant, obs_ack;
  logic          obs_timeout, obs_wcyc, obs_wstb;
  logic [DW-1:0] obs_dat0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                      input logic pack, input logic [DW-1:0] pdat);
    logic         e_fire;
    logic [N-1:0] e_ack;
    bit           found;
    int           idx;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ctrl_bus.adr[i]   = $urandom;
      ctrl_bus.dat_w[i] = $urandom;
      ctrl_bus.we[i]    = 1'($urandom);
      ctrl_bus.sel[i]   = 4'($urandom);
    end
    ctrl_bus.cyc      = cyc;
    ctrl_bus.stb      = stb;
    peri_bus.ack[0]   = pack;
    peri_bus.dat_r[0] = pdat;
    #1;
    e_fire = WD_EN && (m_owner >= 0) && cyc[m_owner] && stb[m_owner] && !pack &&
             (m_cnt == TIMEOUT - 1);
    check("grant", 64'(grant), (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
    if (m_owner >= 0) begin
      check("bus_cyc", 64'(peri_bus.cyc[0]), 64'(cyc[m_owner]));
      check("bus_stb", 64'(peri_bus.stb[0]), 64'(stb[m_owner] && !e_fire));
      check("bus_adr", 64'(peri_bus.adr[0]), 64'(ctrl_bus.adr[m_owner]));
      check("bus_we", 64'(peri_bus.we[0]), 64'(ctrl_bus.we[m_owner]));
      check("bus_dat_w", 64'(peri_bus.dat_w[0]), 64'(ctrl_bus.dat_w[m_owner]));
      check("bus_sel", 64'(peri_bus.sel[0]), 64'(ctrl_bus.sel[m_owner]));
    end else begin
      check("idle_cyc", 64'(peri_bus.cyc[0]), 64'd0);
      check("idle_stb", 64'(peri_bus.stb[0]), 64'd0);
    end
    for (int i = 0; i < N; i++) begin
      e_ack[i] = (i == m_owner) && (pack || e_fire);
      check("ctrl_dat_r", 64'(ctrl_bus.dat_r[i]),
            ((i == m_owner) && !e_fire) ? 64'(pdat) : 64'd0);
    end
    check("ctrl_ack", 64'(ctrl_bus.ack), 64'(e_ack));
    check("timeout", 64'(timeout), 64'(e_fire));
    obs_grant = grant; obs_ack = ctrl_bus.ack; obs_timeout = timeout;
    obs_wcyc = peri_bus.cyc[0]; obs_wstb = peri_bus.stb[0]; obs_dat0 = ctrl_bus.dat_r[0];
    @(posedge clk);
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && cyc[idx]) begin
          found = 1; m_owner = idx; m_cnt = 0;
        end
      end
    end else if (!cyc[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end else if (stb[m_owner] && !pack && !e_fire) begin
      m_cnt++;
    end else begin
      m_cnt = 0;
    end
  endtask

  // Reset asserted between clock edges; its effect must be immediate.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_bus_cyc", 64'(peri_bus.cyc[0]), 64'd0);
    check("rst_ack", 64'(ctrl_bus.ack), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    @(negedge clk);
    ctrl_bus.cyc = '0; ctrl_bus.stb = '0; peri_bus.ack[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_owner = -1; m_last = N - 1; m_cnt = 0;
  endtask

  initial begin
    int            order[$];
    logic [N-1:0]  c, prev, cur;
    logic          a;
    bit            beat;
    int            ack_at, pulses;
    logic          stb_at, dat_at;

    ctrl_bus.cyc = '0; ctrl_bus.stb = '0; ctrl_bus.we = '0; ctrl_bus.adr = '0;
    ctrl_bus.dat_w = '0; ctrl_bus.sel = '0;
    peri_bus.ack = '0; peri_bus.dat_r = '0;
    do_reset();

    // Single request from controller 0
    step(3'b001, 3'b001, 1'b0, 32'h0);
    check("single_idle_grant", 64'(obs_grant), 64'd0);
    step(3'b001, 3'b001, 1'b1, 32'hA5);
    check("single_grant", 64'(obs_grant), 64'b001);
    check("single_bus_cyc", 64'(obs_wcyc), 64'd1);
    check("single_ack", 64'(obs_ack), 64'b001);
    check("single_dat", 64'(obs_dat0), 64'hA5);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    check("single_released", 64'(obs_grant), 64'd0);

    // Contention right after reset
    do_reset();
    step(3'b011, 3'b011, 1'b0, 32'h0);
    step(3'b011, 3'b011, 1'b1, 32'h5A);
    check("cont_first", 64'(obs_grant), 64'b001);
    check("cont_no_ack_1", 64'(obs_ack), 64'b001);
    step(3'b010, 3'b010, 1'b0, 32'h0);
    check("cont_release_cycle", 64'(obs_grant), 64'b001);
    step(3'b010, 3'b010, 1'b1, 32'h0);
    check("cont_gap", 64'(obs_grant), 64'd0);
    check("cont_gap_ack", 64'(obs_ack), 64'd0);
    step(3'b010, 3'b010, 1'b1, 32'h33);
    check("cont_second", 64'(obs_grant), 64'b010);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);

    // Round-robin with all three requesting, one beat per tenure
    do_reset();
    beat = 0; prev = '0;
    for (int s = 0; s < 24; s++) begin
      a = 1'b0;
      c = 3'b111;
      if (m_owner >= 0 && !beat) begin a = 1'b1; beat = 1; end
      else if (m_owner >= 0) c[m_owner] = 1'b0;
      else beat = 0;
      step(c, c, a, $urandom);
      if (obs_grant != 0 && obs_grant != prev)
        for (int i = 0; i < N; i++) if (obs_grant[i]) order.push_back(i);
      prev = obs_grant;
    end
    check("rr_count", 64'(order.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) check("rr_order", 64'(order[i]), 64'(i % 3));
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);

    // Burst hold while controller 1 waits
    do_reset();
    step(3'b011, 3'b001, 1'b0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      step(3'b011, 3'b001, 1'b1, $urandom);
      check("burst_hold", 64'(obs_grant), 64'b001);
      check("burst_ack", 64'(obs_ack), 64'b001);
    end
    step(3'b011, 3'b000, 1'b0, 32'h0);
    check("burst_gap_stb", 64'(obs_grant), 64'b001);
    step(3'b010, 3'b000, 1'b0, 32'h0);
    step(3'b010, 3'b010, 1'b0, 32'h0);
    step(3'b010, 3'b010, 1'b1, 32'h0);
    check("burst_next_owner", 64'(obs_grant), 64'b010);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);

    // Peripheral that never acknowledges
    do_reset();
    step(3'b001, 3'b001, 1'b0, 32'h0);
    ack_at = 0; pulses = 0; stb_at = 1'b1; dat_at = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      step(3'b001, 3'b001, 1'b0, 32'hDEAD_BEEF);
      if (obs_timeout) pulses++;
      if (obs_ack[0] && ack_at == 0) begin
        ack_at = s; stb_at = obs_wstb; dat_at = (obs_dat0 != 0);
      end
    end
    check("wd_ack_cycle", 64'(ack_at), WD_EN ? 64'd8 : 64'd0);
    check("wd_pulses", 64'(pulses), WD_EN ? 64'd1 : 64'd0);
    if (ack_at != 0) begin
      check("wd_stb_low", 64'(stb_at), 64'd0);
      check("wd_dat_zero", 64'(dat_at), 64'd0);
    end
    check("wd_grant_kept", 64'(obs_grant), 64'b001);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);

    // Reset in the middle of controller 1's tenure
    do_reset();
    step(3'b010, 3'b010, 1'b0, 32'h0);
    step(3'b010, 3'b010, 1'b0, 32'h0);
    check("mid_owner", 64'(obs_grant), 64'b010);
    do_reset();
    step(3'b011, 3'b011, 1'b0, 32'h0);
    step(3'b011, 3'b011, 1'b0, 32'h0);
    check("post_rst_priority", 64'(obs_grant), 64'b001);
    step(3'b000, 3'b000, 1'b0, 32'h0);
    step(3'b000, 3'b000, 1'b0, 32'h0);

    // Randomized traffic, with stretches where the peripheral stays silent
    cur = '0;
    for (int s = 0; s < 1500; s++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) cur[i] = ~cur[i];
      c = cur & N'($urandom);
      a = ((s / 100) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      step(cur, c, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
